// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program ROM reader feeding the decode stage over valid/ready
//
// Purpose: drives an asynchronous program ROM from an internal fetch counter,
// registers each returned instruction word and presents it to decode with a
// valid/ready handshake. A jump request redirects fetch. The all-zero word
// marks end-of-program and halts fetch until the next jump or reset.
//
// Optional build macro: FETCH_COUNT_EN adds a saturating 16-bit count of
// accepted handshakes on output fetch_count.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   rom_addr     out  ROM address (current fetch_pc)
//   rom_data     in   ROM word for rom_addr, same cycle
//   instr        out  registered instruction to decode
//   instr_pc     out  address instr was fetched from
//   instr_valid  out  instr/instr_pc hold a live instruction
//   instr_ready  in   decode accepts instr this cycle
//   jump         in   single-cycle redirect request
//   jump_addr    in   redirect target, sampled with jump
//   halted       out  fetch stopped on end-of-program word
//   fetch_count  out  accepted-handshake count (FETCH_COUNT_EN only)

module instr_fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter int          INSTR_W  = 35,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [ADDR_W-1:0]    fetch_pc, fetch_pc_n;
  logic [INSTR_W-1:0]   instr_n;
  logic [ADDR_W-1:0]    instr_pc_n;
  logic                 instr_valid_n;
  logic                 slot_free;

  assign rom_addr  = fetch_pc;
  assign halted    = (state == HALT);
  assign slot_free = !instr_valid || instr_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      fetch_pc    <= ADDR_W'(RESET_PC);
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
    end
  end

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;

    if (jump) begin
      // Redirect wins over everything; the word in the output slot is dropped
      // even if decode accepts it this same cycle.
      fetch_pc_n    = jump_addr;
      instr_valid_n = 1'b0;
      state_n       = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (slot_free) begin
            if (rom_data != '0) begin
              instr_n       = rom_data;
              instr_pc_n    = fetch_pc;
              instr_valid_n = 1'b1;
              fetch_pc_n    = fetch_pc + ADDR_W'(1);
            end else begin
              // End-of-program: fetch_pc stays on the zero word.
              instr_valid_n = 1'b0;
              state_n       = HALT;
            end
          end
        end
        HALT: begin
          instr_valid_n = 1'b0;
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  // Counts accepted words only; a word accepted in the jump cycle is discarded
  // by the redirect, so it is not counted. Survives jumps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= 16'h0000;
    end else if (instr_valid && instr_ready && !jump && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit

module tb_instr_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 35;
  localparam int DEPTH   = 256;
  localparam int SEG_MAX = 600;

  logic               clock;
  logic               reset_n;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump;
  logic [ADDR_W-1:0]  jump_addr;
  logic               halted;
`ifdef FETCH_COUNT_EN
  logic [15:0]        fetch_count;
`endif

  logic [INSTR_W-1:0] mem [DEPTH];
  assign rom_data = mem[rom_addr];

  instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .halted      (halted)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  // Expected program-order stream: {pc, word}
  logic [ADDR_W+INSTR_W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Reference: from start, the program runs in address order (mod 256) up to
  // but not including the first all-zero word.
  task automatic push_segment(input int start);
    int pc;
    pc = start % DEPTH;
    for (int k = 0; k < SEG_MAX; k++) begin
      if (mem[pc] == '0) break;
      exp_q.push_back({pc[ADDR_W-1:0], mem[pc]});
      pc = (pc + 1) % DEPTH;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    reset_n = 1'b1;
    push_segment(0);
  endtask

  task automatic do_jump(input int addr);
    jump      = 1'b1;
    jump_addr = addr[ADDR_W-1:0];
    exp_q.delete();
    push_segment(addr);
    cyc();
    jump = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    for (int k = 0; k < 400; k++) begin
      if (halted) break;
      cyc();
    end
    chk({name, "_halted"}, halted, 1);
    chk({name, "_valid_low"}, instr_valid, 0);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: pops on every accepted handshake, and checks back-pressure holds.
  logic               hold_prev = 1'b0;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;
  int                 model_cnt = 0;

  always @(negedge clock) begin
    logic [ADDR_W+INSTR_W-1:0] e;
    if (!reset_n) begin
      hold_prev = 1'b0;
      model_cnt = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, hold_instr);
        chk("hold_pc", instr_pc, hold_pc);
      end
      if (instr_valid && instr_ready && !jump) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_accept", instr_pc, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", instr_pc, e[ADDR_W+INSTR_W-1:INSTR_W]);
          chk("sb_instr", instr, e[INSTR_W-1:0]);
        end
`ifdef FETCH_COUNT_EN
        chk("sb_fetch_count", fetch_count, model_cnt);
`endif
        if (model_cnt < 65535) model_cnt++;
      end
      hold_prev  = instr_valid && !instr_ready && !jump;
      hold_instr = instr;
      hold_pc    = instr_pc;
    end
  end

  initial begin
    reset_n     = 1'b0;
    instr_ready = 1'b1;
    jump        = 1'b0;
    jump_addr   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < 10; i++) mem[i] = INSTR_W'(i + 1);

    // Reset state
    cyc();
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_rom_addr", rom_addr, 0);

    // Straight-line program 0..9, zero word at 10
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("run_valid", instr_valid, 1);
      chk("run_pc", instr_pc, i);
      chk("run_instr", instr, i + 1);
    end
    cyc();
    chk("eop_halted", halted, 1);
    chk("eop_valid", instr_valid, 0);
    chk("eop_rom_addr", rom_addr, 10);
    chk("eop_drained", exp_q.size(), 0);
    cyc();
    chk("halt_stays", halted, 1);
    chk("halt_rom_addr", rom_addr, 10);

    // Back-pressure with instr_pc=4
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    chk("stall_pc_start", instr_pc, 4);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", instr_pc, 4);
      chk("stall_instr", instr, 5);
      chk("stall_rom_addr", rom_addr, 5);
    end
    instr_ready = 1'b1;
    cyc();
    chk("resume_pc", instr_pc, 5);
    cyc();
    chk("pre_jump_pc", instr_pc, 6);

    // Jump to 2 while instr_pc=6 is valid and ready=1
    do_jump(2);
    chk("jump_bubble", instr_valid, 0);
    cyc();
    chk("jump_tgt_valid", instr_valid, 1);
    chk("jump_tgt_pc", instr_pc, 2);
    chk("jump_tgt_instr", instr, 3);
    wait_halt("jump_run");
    chk("jump_run_rom_addr", rom_addr, 10);

    // Jump out of HALT
    do_jump(0);
    chk("unhalt_halted", halted, 0);
    chk("unhalt_valid", instr_valid, 0);
    cyc();
    chk("unhalt_valid2", instr_valid, 1);
    chk("unhalt_pc", instr_pc, 0);
    wait_halt("unhalt_run");

    // Address wrap with every word non-zero
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom(), 3'($urandom())} | INSTR_W'(1);
    do_jump(250);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("wrap_valid", instr_valid, 1);
      chk("wrap_pc", instr_pc, (250 + i) % DEPTH);
    end

    // Five accepts, then reset mid-stream (asynchronous)
    do_reset();
    for (int i = 0; i < 6; i++) cyc();
`ifdef FETCH_COUNT_EN
    chk("fcnt_five", fetch_count, 5);
`endif
    chk("mid_valid_pre", instr_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("async_valid", instr_valid, 0);
    chk("async_instr", instr, 0);
    chk("async_pc", instr_pc, 0);
    chk("async_rom_addr", rom_addr, 0);
    chk("async_halted", halted, 0);
`ifdef FETCH_COUNT_EN
    chk("async_fcnt", fetch_count, 0);
`endif

    // Randomised program, back-pressure and redirects
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? '0 : ({$urandom(), 3'($urandom())} | INSTR_W'(1));
    mem[$urandom_range(0, DEPTH - 1)] = '0;
    exp_q.delete();
    cyc();
    reset_n = 1'b1;
    push_segment(0);
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if (halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 3))
        do_jump(int'($urandom_range(0, DEPTH - 1)));
      else
        cyc();
    end
    instr_ready = 1'b1;
    do_jump(0);
    wait_halt("rand_final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Reader side of the asynchronous program ROM. It drives the ROM address from an internal fetch counter and registers the 35-bit instruction word returned. The word is presented to the CPU decode stage over a valid/ready handshake. Supports jump redirection and halts on the all-zero end-of-program word.

Parameters:
ADDR_W, 8, program-memory address width; fetch counter wraps modulo 2^ADDR_W
INSTR_W, 35, instruction word width
RESET_PC, 0, first fetch address after reset

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  reset; asynchronous, active-low
rom_addr  output  ADDR_W  address to ROM; combinational copy of fetch_pc register
rom_data  input  INSTR_W  ROM word for rom_addr, valid same cycle (async ROM)
instr  output  INSTR_W  registered instruction to decode
instr_pc  output  ADDR_W  address the presented instr was fetched from
instr_valid  output  1  instr/instr_pc hold a live instruction
instr_ready  input  1  decode accepts instr this cycle
jump  input  1  redirect request, single-cycle pulse
jump_addr  input  ADDR_W  redirect target, sampled when jump=1
halted  output  1  fetch stopped on end-of-program word

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, state=RUN.
- States: RUN, HALT.
- "slot free" = !instr_valid | instr_ready.
- RUN, jump=0, slot free, rom_data != 0: instr<=rom_data, instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+1 (ADDR_W bits, max wraps to 0).
- RUN, jump=0, slot free, rom_data == 0: end-of-program. Word not presented; instr_valid<=0, halted<=1, state<=HALT, fetch_pc unchanged.
- RUN, jump=0, slot not free: hold instr/instr_pc/instr_valid/fetch_pc stable (back-pressure; values must not change while valid & !ready).
- jump=1 (any state, highest priority): fetch_pc<=jump_addr, instr_valid<=0 (held/incoming word discarded even if instr_ready=1 same cycle - decode must treat it as already consumed only if it issued the jump), halted<=0, state<=RUN. Target word captured on following cycle earliest, so first target instruction valid 2 cycles after jump pulse.
- HALT: no captures, instr_valid=0, halted=1, rom_addr holds zero-word address; exits only via jump or reset.
- Throughput: one instruction per cycle with instr_ready held high; latency from fetch_pc update to instr_valid = 1 cycle.
- reset_n asserted mid-stream: immediate return to reset values regardless of handshake.

Optional Feature:
Macro FETCH_COUNT_EN. When defined: extra output fetch_count (16 bits), reset 0, increments on every accepted handshake (instr_valid & instr_ready & !jump), saturates at 16'hFFFF, not cleared by jump. When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then ROM words 1..10 non-zero at addr 0-9, zero at 10, ready=1 -> instr_pc 0..9 on consecutive cycles, then halted=1, instr_valid=0, rom_addr=10.
- Hold instr_ready=0 for 3 cycles with instr_pc=4 valid -> instr, instr_pc=4 and rom_addr=5 stable; resume -> next instr_pc=5, no word skipped or repeated.
- jump=1, jump_addr=8'd2 while instr_pc=6 valid -> next cycle instr_valid=0, following cycle instr_pc=2 valid.
- In HALT, jump to addr 0 -> halted=0 next cycle, instr_pc=0 valid cycle after.
- Non-zero ROM at all 256 addresses, ready=1 -> instr_pc 255 followed by 0 (wrap).
- reset_n low mid-stream with instr_valid=1 -> outputs zero immediately (before clock edge); with FETCH_COUNT_EN, 5 accepts -> fetch_count=5, reset -> 0.
